// File: rtl/rx_deframer_if.sv
// Receive-side HDLC deframer bus: serial line in, payload bytes and
// end-of-frame status out.
interface rx_deframer_if;
  logic       rxdata;
  logic [7:0] data_out;
  logic       data_valid;
  logic       eop;
  logic       frame_ok;
  logic       frame_err;
  logic       abort_det;
  logic       in_frame;

  modport master (
    input  rxdata,
    output data_out,
    output data_valid,
    output eop,
    output frame_ok,
    output frame_err,
    output abort_det,
    output in_frame
  );

  modport slave (
    output rxdata,
    input  data_out,
    input  data_valid,
    input  eop,
    input  frame_ok,
    input  frame_err,
    input  abort_det,
    input  in_frame
  );
endinterface

// File: rtl/rx_deframer.sv
// HDLC receive deframer: flag hunt, zero-bit removal, LSB-first octet
// assembly, CRC-CCITT check, abort detection and FCS stripping.
module rx_deframer #(
  parameter int          MAX_BYTES   = 1600,
  parameter logic [15:0] CRC_RESIDUE = 16'h1D0F
) (
  input  logic netclk,
  input  logic reset,
  rx_deframer_if.master bus
);

  localparam int BW = $clog2(MAX_BYTES + 1);

  typedef enum logic {HUNT, FRAME} state_t;

  state_t        state;
  logic [2:0]    ones;
  logic [2:0]    bitcnt;
  logic [BW-1:0] bytecnt;
  logic [7:0]    shreg;
  logic [7:0]    hold0;
  logic [7:0]    hold1;
  logic [1:0]    hcnt;
  logic [15:0]   lfsr;
  logic [7:0]    data_out;
  logic          data_valid;
  logic          eop;
  logic          frame_ok;
  logic          frame_err;
  logic          abort_det;

  logic          is_abort;
  logic          is_flag;
  logic          is_stuff;
  logic          good;
  logic [7:0]    octet;

  function automatic logic [15:0] crc8(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    logic        f;
    r = c;
    for (int i = 0; i < 8; i++) begin
      f = d[i] ^ r[15];
      r = {r[14:0], 1'b0} ^ ({16{f}} & 16'h1021);
    end
    return r;
  endfunction

  assign is_abort = bus.rxdata && (ones == 3'd6);
  assign is_flag  = !bus.rxdata && (ones == 3'd6);
  assign is_stuff = !bus.rxdata && (ones == 3'd5);
  assign octet    = {bus.rxdata, shreg[7:1]};
  assign good     = (bitcnt == 3'd7) && (bytecnt >= BW'(3))
                 && (lfsr == CRC_RESIDUE);

  always_ff @(posedge netclk) begin
    if (reset) begin
      state      <= HUNT;
      ones       <= 3'd0;
      bitcnt     <= 3'd0;
      bytecnt    <= '0;
      shreg      <= 8'd0;
      hold0      <= 8'd0;
      hold1      <= 8'd0;
      hcnt       <= 2'd0;
      lfsr       <= 16'hFFFF;
      data_out   <= 8'd0;
      data_valid <= 1'b0;
      eop        <= 1'b0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      abort_det  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      eop        <= 1'b0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      abort_det  <= 1'b0;
      if (!bus.rxdata)
        ones <= 3'd0;
      else if (ones != 3'd7)
        ones <= ones + 3'd1;
      unique case (state)
        HUNT: begin
          if (is_flag) begin
            state   <= FRAME;
            bitcnt  <= 3'd0;
            bytecnt <= '0;
            lfsr    <= 16'hFFFF;
            hcnt    <= 2'd0;
          end
        end
        FRAME: begin
          unique case (1'b1)
            is_abort: begin
              abort_det <= (bytecnt != '0);
              state     <= HUNT;
            end
            is_flag: begin
              if (bytecnt != '0) begin
                eop       <= 1'b1;
                frame_ok  <= good;
                frame_err <= !good;
              end
              bitcnt  <= 3'd0;
              bytecnt <= '0;
              lfsr    <= 16'hFFFF;
              hcnt    <= 2'd0;
            end
            is_stuff: begin
            end
            default: begin
              shreg  <= octet;
              bitcnt <= bitcnt + 3'd1;
              if (bitcnt == 3'd7) begin
                if (bytecnt == BW'(MAX_BYTES)) begin
                  eop       <= 1'b1;
                  frame_err <= 1'b1;
                  state     <= HUNT;
                end else begin
                  bytecnt <= bytecnt + BW'(1);
                  lfsr    <= crc8(lfsr, octet);
                  hold1   <= hold0;
                  hold0   <= octet;
                  // two octets held back so the FCS never leaves
                  if (hcnt == 2'd2) begin
                    data_out   <= hold1;
                    data_valid <= 1'b1;
                  end else begin
                    hcnt <= hcnt + 2'd1;
                  end
                end
              end
            end
          endcase
        end
      endcase
    end
  end

  assign bus.data_out   = data_out;
  assign bus.data_valid = data_valid;
  assign bus.eop        = eop;
  assign bus.frame_ok   = frame_ok;
  assign bus.frame_err  = frame_err;
  assign bus.abort_det  = abort_det;
  assign bus.in_frame   = (state == FRAME);

endmodule

// File: tb/tb_rx_deframer.sv
// Scoreboard bench for rx_deframer: a frame-level model predicts the
// output events; a monitor pops and compares them as the DUT emits.
module tb_rx_deframer;

  localparam int          MAXB = 16;
  localparam logic [15:0] RES  = 16'h1D0F;
  localparam int          EV_DATA  = 0;
  localparam int          EV_OK    = 1;
  localparam int          EV_ERR   = 2;
  localparam int          EV_ABORT = 3;

  typedef struct {
    int         kind;
    logic [7:0] b;
  } ev_t;

  logic netclk = 1'b0;
  logic reset;

  rx_deframer_if bus ();

  rx_deframer #(
    .MAX_BYTES  (MAXB),
    .CRC_RESIDUE(RES)
  ) dut (
    .netclk(netclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 netclk = ~netclk;

  ev_t        sbq[$];
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] fr_bytes[$];
  bit         fr_extra[$];

  task automatic chk(input bit ok, input string name,
                     input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [7:0] b);
    ev_t e;
    e.kind = kind;
    e.b    = b;
    sbq.push_back(e);
  endtask

  task automatic pop_check(input int kind, input logic [7:0] b);
    ev_t e;
    if (sbq.size() == 0) begin
      chk(1'b0, "unexpected_output", kind, -1);
    end else begin
      e = sbq.pop_front();
      chk(e.kind == kind, "event_kind", kind, e.kind);
      if (kind == EV_DATA)
        chk(e.b == b, "data_byte", int'(b), int'(e.b));
    end
  endtask

  always @(negedge netclk) begin
    if (!reset) begin
      if (bus.data_valid && bus.eop)
        chk(1'b0, "dv_eop_overlap", 1, 0);
      if (!bus.eop && (bus.frame_ok || bus.frame_err))
        chk(1'b0, "status_without_eop",
            int'({bus.frame_ok, bus.frame_err}), 0);
      if (bus.data_valid)
        pop_check(EV_DATA, bus.data_out);
      if (bus.eop) begin
        chk(bus.frame_ok != bus.frame_err, "status_onehot",
            int'({bus.frame_ok, bus.frame_err}), 1);
        pop_check(bus.frame_ok ? EV_OK : EV_ERR, 8'd0);
      end
      if (bus.abort_det)
        pop_check(EV_ABORT, 8'd0);
    end
  end

  function automatic logic [15:0] crc_oct(input logic [15:0] c,
                                          input logic [7:0] d);
    logic [15:0] r;
    logic        f;
    r = c;
    for (int i = 0; i < 8; i++) begin
      f = d[i] ^ r[15];
      r = {r[14:0], 1'b0};
      if (f) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  task automatic add_fcs(input bit corrupt);
    logic [15:0] l;
    logic [7:0]  b0, b1;
    l = 16'hFFFF;
    foreach (fr_bytes[i]) l = crc_oct(l, fr_bytes[i]);
    for (int k = 0; k < 8; k++) begin
      b0[k] = ~l[15-k];
      b1[k] = ~l[7-k];
    end
    if (corrupt) b1 = b1 ^ (8'd1 << $urandom_range(0, 7));
    fr_bytes.push_back(b0);
    fr_bytes.push_back(b1);
  endtask

  task automatic send_bit(input bit b);
    bus.rxdata = b;
    @(posedge netclk);
    #1;
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) send_bit(f[i]);
  endtask

  // Builds the line image of the current frame; when use_model is set,
  // predicts the receiver's events from the unstuffed bit stream.
  task automatic build_and_send(input bit abort_end, input bit use_model);
    bit          cb[$];
    bit          db[$];
    logic [7:0]  oc[$];
    logic [7:0]  o;
    logic [15:0] l;
    int          c, n, r;
    foreach (fr_bytes[i])
      for (int k = 0; k < 8; k++) cb.push_back(fr_bytes[i][k]);
    foreach (fr_extra[i]) cb.push_back(fr_extra[i]);
    c = 0;
    foreach (cb[i]) begin
      if (cb[i]) begin
        c++;
        if (c == 5) c = 0;
      end else c = 0;
    end
    db = cb;
    if (abort_end) begin
      repeat (6 - c) db.push_back(1'b1);
    end else begin
      db.push_back(1'b0);
      repeat (6) db.push_back(1'b1);
    end
    n = db.size() / 8;
    r = db.size() % 8;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 8; j++) o[j] = db[8*k+j];
      oc.push_back(o);
    end
    if (use_model) begin
      if (n > MAXB) begin
        for (int k = 0; k < MAXB - 2; k++) push_ev(EV_DATA, oc[k]);
        push_ev(EV_ERR, 8'd0);
      end else begin
        for (int k = 0; k < n - 2; k++) push_ev(EV_DATA, oc[k]);
        if (abort_end) begin
          if (n > 0) push_ev(EV_ABORT, 8'd0);
        end else if (n > 0) begin
          l = 16'hFFFF;
          foreach (oc[k]) l = crc_oct(l, oc[k]);
          push_ev((r == 7 && n >= 3 && l == RES) ? EV_OK : EV_ERR, 8'd0);
        end
      end
    end
    send_flag();
    c = 0;
    foreach (cb[i]) begin
      send_bit(cb[i]);
      if (cb[i]) begin
        c++;
        if (c == 5) begin
          send_bit(1'b0);
          c = 0;
        end
      end else c = 0;
    end
    if (abort_end) repeat (8) send_bit(1'b1);
    else send_flag();
  endtask

  task automatic chk_quiet(input string name);
    chk({bus.data_out, bus.data_valid, bus.eop, bus.frame_ok,
         bus.frame_err, bus.abort_det, bus.in_frame} == 14'd0, name,
        int'({bus.data_out, bus.data_valid, bus.eop, bus.frame_ok,
              bus.frame_err, bus.abort_det, bus.in_frame}), 0);
  endtask

  initial begin
    logic [7:0] v;
    int         mode, len;
    bus.rxdata = 1'b1;
    reset      = 1'b1;
    repeat (3) @(posedge netclk);
    #1;
    chk_quiet("reset_outputs");
    reset = 1'b0;

    repeat (10) send_bit(1'b1);
    send_flag();
    chk(bus.in_frame == 1'b1, "in_frame_after_flag", int'(bus.in_frame), 1);
    send_flag();
    repeat (8) send_bit(1'b1);
    chk(bus.in_frame == 1'b0, "hunt_after_idle_ones",
        int'(bus.in_frame), 0);

    fr_bytes = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                8'h38, 8'h39, 8'h6E, 8'h90};
    fr_extra = {};
    for (int k = 0; k < 9; k++) push_ev(EV_DATA, fr_bytes[k]);
    push_ev(EV_OK, 8'd0);
    build_and_send(1'b0, 1'b0);

    fr_bytes[10] = 8'h91;
    for (int k = 0; k < 9; k++) push_ev(EV_DATA, fr_bytes[k]);
    push_ev(EV_ERR, 8'd0);
    build_and_send(1'b0, 1'b0);

    fr_bytes = {8'hFF, 8'hFF, 8'h00, 8'hFF};
    add_fcs(1'b0);
    build_and_send(1'b0, 1'b1);

    fr_bytes = {8'h31, 8'h32, 8'h33};
    build_and_send(1'b1, 1'b1);
    chk(bus.in_frame == 1'b0, "hunt_after_abort", int'(bus.in_frame), 0);

    fr_extra = {1'b1, 1'b0, 1'b1, 1'b1};
    build_and_send(1'b0, 1'b1);
    fr_extra = {};

    fr_bytes = {8'h31};
    build_and_send(1'b0, 1'b1);

    fr_bytes = {};
    for (int k = 0; k < MAXB + 1; k++)
      fr_bytes.push_back(8'($urandom_range(0, 255)));
    build_and_send(1'b0, 1'b1);

    send_flag();
    v = 8'h55;
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    v = 8'hA6;
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    reset = 1'b1;
    @(posedge netclk);
    #1;
    chk_quiet("reset_mid_frame");
    reset = 1'b0;

    for (int f = 0; f < 40; f++) begin
      fr_bytes = {};
      fr_extra = {};
      len  = $urandom_range(0, 18);
      mode = $urandom_range(0, 3);
      for (int k = 0; k < len; k++) begin
        v = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
        fr_bytes.push_back(v);
      end
      if (mode != 3) add_fcs(mode == 1);
      if (mode == 2)
        repeat ($urandom_range(1, 7)) fr_extra.push_back(bit'($urandom_range(0, 1)));
      build_and_send(mode == 3, 1'b1);
    end

    repeat (30) @(posedge netclk);
    chk(sbq.size() == 0, "scoreboard_drain", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
